mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of BUSY cycles without M_MFC before the transaction is aborted.
REQ-002 SHALL have port Clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports F_MFA, F_RW, F_WB, inputs, 1 each: fetch requester request, read(1)/write(0), word(1)/byte(0).
REQ-005 SHALL have ports F_ADDR and F_WDATA, inputs, 32 each: fetch address and write data.
REQ-006 SHALL have ports F_MFC, output, 1, and F_RDATA, output, 32: fetch completion and read data.
REQ-007 SHALL have ports D_MFA, D_RW, D_WB (in, 1), D_ADDR, D_WDATA (in, 32), D_MFC (out, 1), D_RDATA (out, 32): data requester, same meanings as the fetch ports.
REQ-008 SHALL have ports M_MFA, M_RW, M_WB (out, 1), M_ADDR, M_WDATA (out, 32): memory-side request.
REQ-009 SHALL have ports M_MFC (in, 1) and M_RDATA (in, 32): memory completion and read data.
REQ-010 SHALL have ports GRANT (out, 2; bit0 = fetch, bit1 = data, one-hot or zero) and ERR (out, 1; timeout flag).

Function
REQ-011 SHALL implement the states IDLE, BUSY and DONE.
REQ-012 IDLE: with any xMFA=1 at the edge, SHALL select a winner, latch its ADDR/RW/WB/WDATA, set GRANT, and go to BUSY; otherwise SHALL stay in IDLE.
REQ-013 Without MEM_ARB_RR_EN, simultaneous requests SHALL go to data (D) first.
REQ-014 BUSY: SHALL drive M_MFA=1 and M_ADDR/M_RW/M_WB/M_WDATA from the latched values, held stable for the whole state.
REQ-015 BUSY: with M_MFC=1 at the edge, SHALL capture the read data into the winner's xRDATA register and go to DONE with ERR=0.
REQ-016 For a byte read (WB=0), SHALL give xRDATA = {24'b0, M_RDATA[7:0]}; for a word read, xRDATA = M_RDATA.
REQ-017 For a write, SHALL leave xRDATA unchanged.
REQ-018 BUSY: a counter SHALL increment each cycle; reaching TIMEOUT_CYCLES without M_MFC SHALL cause DONE with ERR=1 and xRDATA=0.
REQ-019 DONE: SHALL drive M_MFA=0 and the winner's xMFC=1, held while the winner's xMFA stays 1.
REQ-020 DONE: when the winner's xMFA=0 at the edge, SHALL go to IDLE and clear GRANT, xMFC and ERR.
REQ-021 Minimum latency: request seen at edge 0, M_MFC seen at edge 1, xMFC high after edge 1, IDLE after edge 2 if xMFA drops.
REQ-022 The loser's xMFC SHALL stay 0; its request SHALL be held pending and arbitrated at the next IDLE.
REQ-023 Requests arriving during BUSY or DONE SHALL not disturb the current transaction.
REQ-024 M_MFC asserted in IDLE or DONE SHALL be ignored.
REQ-025 The counter SHALL saturate and clear on entry to BUSY.

Reset
REQ-026 Reset=0 SHALL, at any time including mid-transaction, force state IDLE with all outputs 0.
REQ-027 Reset=0 SHALL clear GRANT to 00 and zero xRDATA, the counter and ERR.
REQ-028 Reset=0 SHALL set last-grant to data; any in-flight transaction is abandoned.
REQ-029 After Reset returns to 1, the first arbitration SHALL occur at the next rising edge.

Configuration
REQ-030 The macro MEM_ARB_RR_EN, when defined, SHALL enable round-robin arbitration.
REQ-031 With MEM_ARB_RR_EN, simultaneous requests SHALL grant the requester not granted last; last-grant updates on each BUSY entry, so after reset fetch wins first.
REQ-032 Without MEM_ARB_RR_EN, fixed priority data > fetch SHALL apply and there SHALL be no last-grant register.

Verification
REQ-033 Fetch read word at F_ADDR=0x10, M_RDATA=0xDEADBEEF, M_MFC one cycle after M_MFA -> GRANT=01, M_ADDR=0x10, F_RDATA=0xDEADBEEF, F_MFC=1, ERR=0.
REQ-034 Byte read by D with M_RDATA=0x123456AB -> D_RDATA=0x000000AB, D_MFC=1, F_MFC=0.
REQ-035 F_MFA and D_MFA rise together, both held -> without the macro D then F; with MEM_ARB_RR_EN F then D then F.
REQ-036 M_MFC never asserted -> after 16 BUSY cycles DONE with ERR=1, F_RDATA=0; IDLE once F_MFA drops.
REQ-037 Reset driven low while in BUSY with M_MFA=1 -> M_MFA, GRANT, xMFC and ERR are 0 immediately (asynchronous); a new request is served normally after release.
REQ-038 Write D_ADDR=0x20, D_WDATA=0xCAFE0001 with F_MFA rising during BUSY -> M_WDATA stable at 0xCAFE0001, D_MFC=1, then fetch granted at the following IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory port.
// The arbiter takes the slave modport; the requester/memory side takes master.
interface mem_arbiter_if;
   logic        F_MFA, F_RW, F_WB, F_MFC;
   logic [31:0] F_ADDR, F_WDATA, F_RDATA;
   logic        D_MFA, D_RW, D_WB, D_MFC;
   logic [31:0] D_ADDR, D_WDATA, D_RDATA;
   logic        M_MFA, M_RW, M_WB, M_MFC;
   logic [31:0] M_ADDR, M_WDATA, M_RDATA;
   logic [1:0]  GRANT;
   logic        ERR;

   modport slave (
      input  F_MFA, F_RW, F_WB, F_ADDR, F_WDATA,
      input  D_MFA, D_RW, D_WB, D_ADDR, D_WDATA,
      input  M_MFC, M_RDATA,
      output F_MFC, F_RDATA, D_MFC, D_RDATA,
      output M_MFA, M_RW, M_WB, M_ADDR, M_WDATA,
      output GRANT, ERR
   );

   modport master (
      output F_MFA, F_RW, F_WB, F_ADDR, F_WDATA,
      output D_MFA, D_RW, D_WB, D_ADDR, D_WDATA,
      output M_MFC, M_RDATA,
      input  F_MFC, F_RDATA, D_MFC, D_RDATA,
      input  M_MFA, M_RW, M_WB, M_ADDR, M_WDATA,
      input  GRANT, ERR
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) memory arbiter, IDLE->BUSY->DONE; 2 cycles minimum, TIMEOUT_CYCLES abort.
// Fixed data>fetch priority by default; define MEM_ARB_RR_EN for round-robin. Winner holds DONE until it drops xMFA.
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic          Clk,
   input logic          Reset,
   mem_arbiter_if.slave bus
);
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_grant;
   logic [31:0]   r_addr, r_wdata, r_f_rdata, r_d_rdata;
   logic          r_rw, r_wb, r_err;
   logic [CW-1:0] r_cnt;
   logic          w_pick_d, w_win_mfa, w_timeout;
   logic [31:0]   w_rdata_cap;

`ifdef MEM_ARB_RR_EN
   logic r_last_d;
   // Data wins a tie only when fetch was granted last.
   assign w_pick_d = bus.D_MFA & (~bus.F_MFA | ~r_last_d);
`else
   assign w_pick_d = bus.D_MFA;
`endif

   assign w_win_mfa   = r_grant[1] ? bus.D_MFA : bus.F_MFA;
   assign w_timeout   = (r_cnt == CNT_LAST);
   assign w_rdata_cap = r_wb ? bus.M_RDATA : {24'b0, bus.M_RDATA[7:0]};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      bus.M_MFA    = 1'b0;
      bus.M_RW     = 1'b0;
      bus.M_WB     = 1'b0;
      bus.M_ADDR   = 32'b0;
      bus.M_WDATA  = 32'b0;
      bus.F_MFC    = 1'b0;
      bus.D_MFC    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.F_MFA || bus.D_MFA) w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            bus.M_MFA   = 1'b1;
            bus.M_RW    = r_rw;
            bus.M_WB    = r_wb;
            bus.M_ADDR  = r_addr;
            bus.M_WDATA = r_wdata;
            if (bus.M_MFC || w_timeout) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            bus.F_MFC = r_grant[0];
            bus.D_MFC = r_grant[1];
            if (!w_win_mfa) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_grant   <= 2'b00;
         r_addr    <= 32'b0;
         r_wdata   <= 32'b0;
         r_rw      <= 1'b0;
         r_wb      <= 1'b0;
         r_err     <= 1'b0;
         r_cnt     <= '0;
         r_f_rdata <= 32'b0;
         r_d_rdata <= 32'b0;
`ifdef MEM_ARB_RR_EN
         r_last_d  <= 1'b1;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.F_MFA || bus.D_MFA) begin
                  r_grant <= w_pick_d ? 2'b10 : 2'b01;
                  r_addr  <= w_pick_d ? bus.D_ADDR  : bus.F_ADDR;
                  r_wdata <= w_pick_d ? bus.D_WDATA : bus.F_WDATA;
                  r_rw    <= w_pick_d ? bus.D_RW    : bus.F_RW;
                  r_wb    <= w_pick_d ? bus.D_WB    : bus.F_WB;
                  r_cnt   <= '0;
`ifdef MEM_ARB_RR_EN
                  r_last_d <= w_pick_d;
`endif
               end
            end
            S_BUSY: begin
               if (bus.M_MFC) begin
                  r_err <= 1'b0;
                  if (r_rw) begin
                     if (r_grant[1]) r_d_rdata <= w_rdata_cap;
                     else            r_f_rdata <= w_rdata_cap;
                  end
               end else if (w_timeout) begin
                  r_err <= 1'b1;
                  if (r_grant[1]) r_d_rdata <= 32'b0;
                  else            r_f_rdata <= 32'b0;
               end else begin
                  // Never passes CNT_LAST: the timeout branch leaves BUSY first.
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (!w_win_mfa) begin
                  r_grant <= 2'b00;
                  r_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.GRANT   = r_grant;
   assign bus.ERR     = r_err;
   assign bus.F_RDATA = r_f_rdata;
   assign bus.D_RDATA = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, byte read, tie arbitration, timeout, async reset, write with late fetch.
module tb_mem_arbiter;
   logic Clk;
   logic Reset;
   int   n_tests;
   int   n_fail;
   logic [1:0] first_w, second_w;

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_mfa(input logic [1:0] who, input logic v);
      if (who[0]) bus.F_MFA = v;
      if (who[1]) bus.D_MFA = v;
   endtask

   function automatic logic mfc_of(input logic [1:0] who);
      return who[1] ? bus.D_MFC : bus.F_MFC;
   endfunction

   function automatic logic [31:0] rdata_of(input logic [1:0] who);
      return who[1] ? bus.D_RDATA : bus.F_RDATA;
   endfunction

   task automatic complete(input logic [31:0] data);
      bus.M_MFC   = 1'b1;
      bus.M_RDATA = data;
      tick();
      bus.M_MFC   = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      Reset = 1'b0;
      bus.F_MFA = 0; bus.F_RW = 0; bus.F_WB = 0; bus.F_ADDR = 0; bus.F_WDATA = 0;
      bus.D_MFA = 0; bus.D_RW = 0; bus.D_WB = 0; bus.D_ADDR = 0; bus.D_WDATA = 0;
      bus.M_MFC = 0; bus.M_RDATA = 0;
      #2;
      check_val("rst_grant", 32'(bus.GRANT), 32'h0);
      check_val("rst_m_mfa", 32'(bus.M_MFA), 32'h0);
      check_val("rst_err",   32'(bus.ERR),   32'h0);
      check_val("rst_frdata", bus.F_RDATA,   32'h0);
      #10 Reset = 1'b1;
      tick();

      // Fetch word read, memory answers one cycle after M_MFA.
      bus.F_MFA = 1; bus.F_RW = 1; bus.F_WB = 1; bus.F_ADDR = 32'h10;
      tick();
      check_val("f_rd_grant", 32'(bus.GRANT), 32'h1);
      check_val("f_rd_m_mfa", 32'(bus.M_MFA), 32'h1);
      check_val("f_rd_m_addr", bus.M_ADDR,    32'h10);
      complete(32'hDEADBEEF);
      check_val("f_rd_mfc",   32'(bus.F_MFC), 32'h1);
      check_val("f_rd_data",  bus.F_RDATA,    32'hDEADBEEF);
      check_val("f_rd_err",   32'(bus.ERR),   32'h0);
      check_val("f_rd_m_mfa0", 32'(bus.M_MFA), 32'h0);
      tick();
      check_val("f_rd_mfc_hold", 32'(bus.F_MFC), 32'h1);
      bus.F_MFA = 0;
      tick();
      check_val("f_rd_idle_grant", 32'(bus.GRANT), 32'h0);
      check_val("f_rd_idle_mfc",   32'(bus.F_MFC), 32'h0);

      // M_MFC in IDLE with no request does nothing.
      bus.M_MFC = 1; bus.M_RDATA = 32'h77777777;
      tick();
      bus.M_MFC = 0;
      check_val("idle_mfc_grant", 32'(bus.GRANT), 32'h0);
      check_val("idle_mfc_drdata", bus.D_RDATA,   32'h0);

      // Data byte read.
      bus.D_MFA = 1; bus.D_RW = 1; bus.D_WB = 0; bus.D_ADDR = 32'h44;
      tick();
      check_val("d_byte_grant", 32'(bus.GRANT), 32'h2);
      check_val("d_byte_m_wb",  32'(bus.M_WB),  32'h0);
      complete(32'h123456AB);
      check_val("d_byte_data", bus.D_RDATA,    32'h000000AB);
      check_val("d_byte_dmfc", 32'(bus.D_MFC), 32'h1);
      check_val("d_byte_fmfc", 32'(bus.F_MFC), 32'h0);
      bus.D_MFA = 0;
      tick();
      check_val("d_byte_idle", 32'(bus.GRANT), 32'h0);

      // Simultaneous requests; the first winner re-requests during the second transaction.
`ifdef MEM_ARB_RR_EN
      first_w = 2'b01;
`else
      first_w = 2'b10;
`endif
      second_w = first_w ^ 2'b11;
      bus.F_RW = 1; bus.F_WB = 1; bus.F_ADDR = 32'h100;
      bus.D_RW = 1; bus.D_WB = 1; bus.D_ADDR = 32'h200;
      bus.F_MFA = 1; bus.D_MFA = 1;
      tick();
      check_val("tie1_grant", 32'(bus.GRANT), 32'(first_w));
      check_val("tie1_addr",  bus.M_ADDR, first_w[1] ? 32'h200 : 32'h100);
      complete(32'hA1A1A1A1);
      check_val("tie1_win_mfc",  32'(mfc_of(first_w)),  32'h1);
      check_val("tie1_lose_mfc", 32'(mfc_of(second_w)), 32'h0);
      check_val("tie1_data",     rdata_of(first_w),     32'hA1A1A1A1);
      set_mfa(first_w, 1'b0);
      tick();
      check_val("tie1_idle", 32'(bus.GRANT), 32'h0);
      tick();
      check_val("tie2_grant", 32'(bus.GRANT), 32'(second_w));
      set_mfa(first_w, 1'b1);
      tick();
      check_val("tie2_grant_stable", 32'(bus.GRANT), 32'(second_w));
      complete(32'hB2B2B2B2);
      check_val("tie2_win_mfc",  32'(mfc_of(second_w)), 32'h1);
      check_val("tie2_lose_mfc", 32'(mfc_of(first_w)),  32'h0);
      check_val("tie2_data",     rdata_of(second_w),    32'hB2B2B2B2);
      set_mfa(second_w, 1'b0);
      tick();
      tick();
      check_val("tie3_grant", 32'(bus.GRANT), 32'(first_w));
      complete(32'hC3C3C3C3);
      set_mfa(first_w, 1'b0);
      tick();

      // Timeout: 16 BUSY cycles without M_MFC.
      bus.F_MFA = 1; bus.F_RW = 1; bus.F_WB = 1; bus.F_ADDR = 32'h30;
      tick();
      for (int i = 0; i < 15; i++) tick();
      check_val("to_busy_15", 32'(bus.M_MFA), 32'h1);
      check_val("to_err_15",  32'(bus.ERR),   32'h0);
      tick();
      check_val("to_err",   32'(bus.ERR),   32'h1);
      check_val("to_mfc",   32'(bus.F_MFC), 32'h1);
      check_val("to_rdata", bus.F_RDATA,    32'h0);
      check_val("to_m_mfa", 32'(bus.M_MFA), 32'h0);
      complete(32'h99999999);
      check_val("done_mfc_ignored", bus.F_RDATA, 32'h0);
      bus.F_MFA = 0;
      tick();
      check_val("to_idle_err", 32'(bus.ERR),   32'h0);
      check_val("to_idle_mfc", 32'(bus.F_MFC), 32'h0);

      // Asynchronous reset in the middle of a BUSY transaction.
      bus.D_MFA = 1; bus.D_RW = 1; bus.D_WB = 1; bus.D_ADDR = 32'h50;
      tick();
      check_val("ar_busy", 32'(bus.M_MFA), 32'h1);
      #2 Reset = 1'b0;
      #1;
      check_val("ar_m_mfa",  32'(bus.M_MFA), 32'h0);
      check_val("ar_grant",  32'(bus.GRANT), 32'h0);
      check_val("ar_dmfc",   32'(bus.D_MFC), 32'h0);
      check_val("ar_err",    32'(bus.ERR),   32'h0);
      check_val("ar_frdata", bus.F_RDATA,    32'h0);
      bus.D_MFA = 0;
      #1 Reset = 1'b1;
      bus.F_MFA = 1; bus.F_RW = 1; bus.F_WB = 1; bus.F_ADDR = 32'h60;
      tick();
      check_val("ar_new_grant", 32'(bus.GRANT), 32'h1);
      check_val("ar_new_addr",  bus.M_ADDR,     32'h60);
      complete(32'h55AA55AA);
      check_val("ar_new_data", bus.F_RDATA, 32'h55AA55AA);
      bus.F_MFA = 0;
      tick();

      // Data write; fetch arrives mid-BUSY and the data inputs change under it.
      bus.D_MFA = 1; bus.D_RW = 0; bus.D_WB = 1; bus.D_ADDR = 32'h20; bus.D_WDATA = 32'hCAFE0001;
      tick();
      check_val("wr_grant", 32'(bus.GRANT), 32'h2);
      bus.F_MFA = 1; bus.F_RW = 1; bus.F_WB = 1; bus.F_ADDR = 32'h40;
      bus.D_ADDR = 32'h24; bus.D_WDATA = 32'h0BAD0BAD;
      tick();
      check_val("wr_grant_hold", 32'(bus.GRANT), 32'h2);
      check_val("wr_m_wdata",    bus.M_WDATA,    32'hCAFE0001);
      check_val("wr_m_addr",     bus.M_ADDR,     32'h20);
      check_val("wr_m_rw",       32'(bus.M_RW),  32'h0);
      complete(32'hFFFFFFFF);
      check_val("wr_dmfc",   32'(bus.D_MFC), 32'h1);
      check_val("wr_fmfc",   32'(bus.F_MFC), 32'h0);
      check_val("wr_drdata", bus.D_RDATA,    32'h0);
      bus.D_MFA = 0;
      tick();
      tick();
      check_val("wr_then_f", 32'(bus.GRANT), 32'h1);
      check_val("wr_then_f_addr", bus.M_ADDR, 32'h40);
      complete(32'h0000BEEF);
      check_val("wr_then_f_data", bus.F_RDATA, 32'h0000BEEF);
      bus.F_MFA = 0;
      tick();
      check_val("final_idle", 32'(bus.GRANT), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
